// File: rtl/param_rom_pkg.sv
// Shared types and defaults for the ROM streaming controller.
package param_rom_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/param_rom_stream_ctrl_if.sv
// Job control, ROM port and output stream signals of the ROM streaming controller.
interface param_rom_stream_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int PASS_WIDTH = 8
);
  logic                  start;
  logic [PASS_WIDTH-1:0] num_passes;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_ce;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  data_out_last;

  modport master (
    input  start, num_passes, rom_q, data_out_ready,
    output busy, done, rom_addr, rom_ce, data_out, data_out_valid, data_out_last
  );

  modport slave (
    output start, num_passes, rom_q, data_out_ready,
    input  busy, done, rom_addr, rom_ce, data_out, data_out_valid, data_out_last
  );
endinterface

// File: rtl/param_stream_fifo.sv
// Synchronous output buffer; read data is forced to zero while empty.
module param_stream_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= ptr_inc(wr_q);
      if (pop_i)  rd_q <= ptr_inc(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign valid_o = (cnt_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/param_rom_stream_ctrl.sv
// Streams num_passes full sweeps of a pipelined ROM into a ready/valid output,
// issuing reads only when the output buffer has room for every word in flight.
//   state   | meaning
//   S_IDLE  | waiting for start; ROM disabled
//   S_RUN   | issuing ROM reads under credit control
//   S_DRAIN | all reads issued; waiting for pipeline and buffer to empty
module param_rom_stream_ctrl
  import param_rom_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 24,
  parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int PASS_WIDTH  = 8
) (
  input logic                     clk,
  input logic                     rst,
  param_rom_stream_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(ROM_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [PASS_WIDTH-1:0]  pass_q, pass_d, npass_q, npass_d;
  logic [ROM_LATENCY-1:0] tag_vld_q, tag_vld_d, tag_last_q, tag_last_d;
  logic                   done_q, done_d;

  logic                   issue, addr_end, push, pop;
  logic [INF_W-1:0]       inflight;
  logic [CNT_W-1:0]       fifo_count;
  logic [DATA_WIDTH:0]    fifo_rdata;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) inflight = inflight + INF_W'(tag_vld_q[i]);
  end

  // Credit covers buffered words plus every read still in the ROM pipeline.
  assign issue    = (state_q == S_RUN) && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
  assign addr_end = (addr_q == LAST_ADDR);
  assign push     = tag_vld_q[ROM_LATENCY-1];
  assign pop      = bus.data_out_valid && bus.data_out_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    npass_d = npass_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.num_passes != '0) begin
            state_d = S_RUN;
            npass_d = bus.num_passes;
            addr_d  = '0;
            pass_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          if (addr_end) begin
            addr_d = '0;
            pass_d = pass_q + 1'b1;
            if (pass_q == npass_q - PASS_WIDTH'(1)) state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if ((inflight == '0) && (fifo_count == '0)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tag_vld_d     = '0;
    tag_last_d    = '0;
    tag_vld_d[0]  = issue;
    tag_last_d[0] = issue && addr_end;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_last_d[i] = tag_last_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      pass_q     <= '0;
      npass_q    <= '0;
      tag_vld_q  <= '0;
      tag_last_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pass_q     <= pass_d;
      npass_q    <= npass_d;
      tag_vld_q  <= tag_vld_d;
      tag_last_q <= tag_last_d;
      done_q     <= done_d;
    end
  end

  param_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({tag_last_q[ROM_LATENCY-1], bus.rom_q}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .valid_o (bus.data_out_valid),
    .count_o (fifo_count)
  );

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.rom_ce        = (state_q != S_IDLE);
  assign bus.done          = done_q;
  assign bus.rom_addr      = addr_q;
  assign bus.data_out      = fifo_rdata[DATA_WIDTH-1:0];
  assign bus.data_out_last = fifo_rdata[DATA_WIDTH];
endmodule

// File: tb/tb_param_rom_stream_ctrl.sv
// Directed bench for param_rom_stream_ctrl with a 2-stage ROM whose word i is i+1.
module tb_param_rom_stream_ctrl;
  import param_rom_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 24;
  localparam int AW    = $clog2(DEPTH) + 1;
  localparam int PW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  param_rom_stream_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PASS_WIDTH(PW)) bus ();

  param_rom_stream_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .ROM_LATENCY(2), .FIFO_DEPTH(4), .PASS_WIDTH(PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] rom_s1, rom_s2;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_s1 <= '0;
      rom_s2 <= '0;
    end else if (bus.rom_ce) begin
      rom_s1 <= DW'(bus.rom_addr) + 1;
      rom_s2 <= rom_s1;
    end
  end
  assign bus.rom_q = rom_s2;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         passes;
    logic [3:0] pat;
    bit         poke;
    int         exp_words;
    int         exp_lasts;
    int         exp_first;
    bit         chk_bubbles;
  } vec_t;

  vec_t vecs[6];

  task automatic run_job(input int passes, input logic [3:0] pat, input bit poke,
                         output int words, output int lasts, output int order_err,
                         output int stab_err, output int first_e, output int done_cnt,
                         output int done_gap, output int bubbles, output int max_cnt,
                         output int busy_seen);
    int done_e, last_hs, c;
    logic prev_stall, held_l;
    logic [DW-1:0] held_d;
    words = 0; lasts = 0; order_err = 0; stab_err = 0; first_e = -1;
    done_cnt = 0; bubbles = 0; max_cnt = 0; busy_seen = 0;
    done_e = -1; last_hs = -2; prev_stall = 1'b0; held_d = '0; held_l = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_passes = PW'(passes);
    bus.data_out_ready = pat[0];
    for (int e = 0; e < 600; e++) begin
      @(negedge clk);
      bus.start = poke && (e == 9);
      bus.num_passes = (poke && e == 9) ? PW'(5) : PW'(passes);
      bus.data_out_ready = pat[e % 4];
      #1;
      if (bus.busy) busy_seen = 1;
      if (bus.done) begin
        done_cnt++;
        if (done_e < 0) done_e = e;
      end
      c = int'(dut.u_fifo.count_o);
      if (c > max_cnt) max_cnt = c;
      if (prev_stall && (!bus.data_out_valid || bus.data_out != held_d || bus.data_out_last != held_l))
        stab_err++;
      if (bus.data_out_valid) begin
        if (first_e < 0) first_e = e;
      end else if (first_e >= 0 && words < passes * DEPTH) begin
        bubbles++;
      end
      if (bus.data_out_valid && bus.data_out_ready) begin
        if (int'(bus.data_out) != (words % DEPTH) + 1 ||
            bus.data_out_last != ((words % DEPTH) == DEPTH - 1))
          order_err++;
        if (bus.data_out_last) lasts++;
        words++;
        last_hs = e;
      end
      prev_stall = bus.data_out_valid && !bus.data_out_ready;
      held_d = bus.data_out;
      held_l = bus.data_out_last;
      if (done_e >= 0 && e >= done_e + 3) break;
    end
    done_gap = done_e - last_hs;
    bus.start = 1'b0;
  endtask

  initial begin
    int w, l, oe, se, fe, dc, dg, bb, mc, bs, hs;
    bit reached;
    bus.start = 1'b0;
    bus.num_passes = '0;
    bus.data_out_ready = 1'b1;

    vecs[0] = '{passes: 1, pat: 4'b1111, poke: 1'b0, exp_words: 24, exp_lasts: 1, exp_first: 3, chk_bubbles: 1'b1};
    vecs[1] = '{passes: 3, pat: 4'b1111, poke: 1'b0, exp_words: 72, exp_lasts: 3, exp_first: 3, chk_bubbles: 1'b1};
    vecs[2] = '{passes: 2, pat: 4'b1001, poke: 1'b0, exp_words: 48, exp_lasts: 2, exp_first: 3, chk_bubbles: 1'b0};
    vecs[3] = '{passes: 0, pat: 4'b1111, poke: 1'b0, exp_words: 0,  exp_lasts: 0, exp_first: -1, chk_bubbles: 1'b0};
    vecs[4] = '{passes: 1, pat: 4'b1111, poke: 1'b1, exp_words: 24, exp_lasts: 1, exp_first: 3, chk_bubbles: 1'b1};
    vecs[5] = '{passes: 2, pat: 4'b0101, poke: 1'b0, exp_words: 48, exp_lasts: 2, exp_first: 3, chk_bubbles: 1'b0};

    repeat (3) @(negedge clk);
    check("reset_busy",  int'(bus.busy), 0);
    check("reset_done",  int'(bus.done), 0);
    check("reset_ce",    int'(bus.rom_ce), 0);
    check("reset_addr",  int'(bus.rom_addr), 0);
    check("reset_valid", int'(bus.data_out_valid), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_job(vecs[v].passes, vecs[v].pat, vecs[v].poke, w, l, oe, se, fe, dc, dg, bb, mc, bs);
      check($sformatf("v%0d_words", v), w, vecs[v].exp_words);
      check($sformatf("v%0d_lasts", v), l, vecs[v].exp_lasts);
      check($sformatf("v%0d_order", v), oe, 0);
      check($sformatf("v%0d_stable", v), se, 0);
      check($sformatf("v%0d_first_valid", v), fe, vecs[v].exp_first);
      check($sformatf("v%0d_done_count", v), dc, 1);
      check($sformatf("v%0d_done_gap", v), dg, 2);
      check($sformatf("v%0d_fifo_le4", v), int'(mc <= 4), 1);
      check($sformatf("v%0d_busy_seen", v), bs, int'(vecs[v].passes != 0));
      check($sformatf("v%0d_busy_end", v), int'(bus.busy), 0);
      if (vecs[v].chk_bubbles) check($sformatf("v%0d_bubbles", v), bb, 0);
      repeat (2) @(negedge clk);
    end

    // Abort a 2-pass job with reset right after the tenth word is taken.
    bus.data_out_ready = 1'b1;
    bus.num_passes = PW'(2);
    bus.start = 1'b1;
    hs = 0;
    reached = 1'b0;
    for (int e = 0; e < 100; e++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.data_out_valid && bus.data_out_ready) hs++;
      if (hs == 10) begin
        reached = 1'b1;
        break;
      end
    end
    check("abort_reached", int'(reached), 1);
    rst = 1'b0;
    #1;
    check("abort_busy",  int'(bus.busy), 0);
    check("abort_done",  int'(bus.done), 0);
    check("abort_ce",    int'(bus.rom_ce), 0);
    check("abort_addr",  int'(bus.rom_addr), 0);
    check("abort_valid", int'(bus.data_out_valid), 0);
    check("abort_last",  int'(bus.data_out_last), 0);
    check("abort_data",  int'(bus.data_out), 0);
    dc = 0;
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    check("abort_no_done", dc, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_job(1, 4'b1111, 1'b0, w, l, oe, se, fe, dc, dg, bb, mc, bs);
    check("post_words", w, 24);
    check("post_order", oe, 0);
    check("post_first_valid", fe, 3);
    check("post_done_count", dc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
